simmem_bank_timing: RTL and testbench

- Parametrised multi-bank DRAM timing model for the simulated memory controller.
- Maps each request address to a bank and row, and tracks the open row per bank.
- Charges row-hit, precharge and activation costs, and supports an open-page or closed-page policy.
- Returns the request id, the measured delay and a row-hit flag. Sits between the AXI address intake and the delay calculator/response banks.

---
 rtl/simmem_bank_timing.sv | 232 +++++++++++++++++++++++
 tb/tb_simmem_bank_timing.sv | 294 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/simmem_bank_timing.sv
// -----------------------------------------------------------------------------
// simmem_bank_timing
//
// Multi-bank DRAM timing model for the simulated memory controller. Each
// request address is split into a bank index and a row id. Every bank runs a
// small phase FSM (PRECHARGE / ACTIVATE / ACCESS) that charges the cost of a
// row hit, a closed row or a row conflict. Once the bank is finished it waits
// in DONE until its response is accepted. Completed banks are arbitrated onto
// a single response channel that carries the id, the measured delay and a
// row-hit flag.
//
// Ports
//   clk_i          clock
//   rst_ni         asynchronous active-low reset
//   req_valid_i    request valid
//   req_ready_o    request ready (target bank of req_addr_i is idle)
//   req_addr_i     request byte address
//   req_id_i       request id
//   rsp_valid_o    response valid (some bank is DONE)
//   rsp_ready_i    response ready
//   rsp_id_o       id of the completed request
//   rsp_delay_o    cycles from request handshake to response handshake, saturating
//   rsp_row_hit_o  request hit the open row
//   bank_busy_o    per-bank not-idle flags
// -----------------------------------------------------------------------------
module simmem_bank_timing #(
  parameter int AddrW          = 16,
  parameter int IdW            = 2,
  parameter int NumBanks       = 4,
  parameter int RowBufLenW     = 8,
  parameter int RowHitCost     = 4,
  parameter int PrechargeCost  = 2,
  parameter int ActivationCost = 1,
  parameter bit OpenPage       = 1'b1,
  parameter int DelayW         = 6
) (
  input  logic                clk_i,
  input  logic                rst_ni,
  input  logic                req_valid_i,
  output logic                req_ready_o,
  input  logic [AddrW-1:0]    req_addr_i,
  input  logic [IdW-1:0]      req_id_i,
  output logic                rsp_valid_o,
  input  logic                rsp_ready_i,
  output logic [IdW-1:0]      rsp_id_o,
  output logic [DelayW-1:0]   rsp_delay_o,
  output logic                rsp_row_hit_o,
  output logic [NumBanks-1:0] bank_busy_o
);

  localparam int BankW   = (NumBanks > 1) ? $clog2(NumBanks) : 1;
  localparam int RowW    = AddrW - RowBufLenW - BankW;
  localparam int MaxCost = (RowHitCost > PrechargeCost) ?
                           ((RowHitCost > ActivationCost) ? RowHitCost : ActivationCost) :
                           ((PrechargeCost > ActivationCost) ? PrechargeCost : ActivationCost);
  localparam int CntW    = (MaxCost > 1) ? $clog2(MaxCost) : 1;
  localparam logic [DelayW-1:0] DelayMax = '1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_PRE,
    S_ACT,
    S_ACC,
    S_DONE
  } bank_st_e;

  // Per-bank state
  bank_st_e          r_state    [NumBanks];
  logic [CntW-1:0]   r_cnt      [NumBanks];
  logic [IdW-1:0]    r_id       [NumBanks];
  logic [RowW-1:0]   r_row      [NumBanks];
  logic [RowW-1:0]   r_open_row [NumBanks];
  logic [DelayW-1:0] r_delay    [NumBanks];
  logic [NumBanks-1:0] r_hit;
  logic [NumBanks-1:0] r_row_valid;

  // Response grant lock
  logic             r_lock;
  logic [BankW-1:0] r_gnt;

  logic [BankW-1:0]    w_req_bank;
  logic [RowW-1:0]     w_req_row;
  logic                w_req_hs;
  logic [NumBanks-1:0] w_done;
  logic [BankW-1:0]    w_low_done;
  logic [BankW-1:0]    w_gnt;
  logic                w_rsp_valid;
  logic                w_rsp_hs;

  // A phase of cost c is held for c cycles: load c-1 and leave at zero.
  function automatic logic [CntW-1:0] phase_load(input int cost);
    return CntW'(cost - 1);
  endfunction

  function automatic logic [DelayW-1:0] sat_inc(input logic [DelayW-1:0] v);
    return (v == DelayMax) ? v : v + 1'b1;
  endfunction

  // Address decode; a single-bank build always targets bank 0
  always_comb begin
    w_req_bank = '0;
    if (NumBanks > 1) begin
      w_req_bank = req_addr_i[RowBufLenW +: BankW];
    end
  end

  assign w_req_row = req_addr_i[AddrW-1 -: RowW];

  // Ready is forced low while reset is asserted, independent of the clock
  assign req_ready_o = rst_ni && (r_state[w_req_bank] == S_IDLE);
  assign w_req_hs    = req_valid_i && req_ready_o;

  always_comb begin
    w_done      = '0;
    bank_busy_o = '0;
    for (int b = 0; b < NumBanks; b++) begin
      w_done[b]      = (r_state[b] == S_DONE);
      bank_busy_o[b] = (r_state[b] != S_IDLE);
    end
  end

  // Lowest-index DONE bank; scanned downwards so the lowest index wins
  always_comb begin
    w_low_done = '0;
    for (int b = NumBanks - 1; b >= 0; b--) begin
      if (w_done[b]) begin
        w_low_done = BankW'(b);
      end
    end
  end

  // A stalled response keeps its bank selected, so the outputs cannot change
  // under a pending handshake even if a lower bank completes meanwhile.
  assign w_gnt       = r_lock ? r_gnt : w_low_done;
  assign w_rsp_valid = |w_done;
  assign w_rsp_hs    = w_rsp_valid && rsp_ready_i;

  assign rsp_valid_o   = w_rsp_valid;
  assign rsp_id_o      = w_rsp_valid ? r_id[w_gnt]    : '0;
  assign rsp_delay_o   = w_rsp_valid ? r_delay[w_gnt] : '0;
  assign rsp_row_hit_o = w_rsp_valid && r_hit[w_gnt];

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_lock      <= 1'b0;
      r_gnt       <= '0;
      r_hit       <= '0;
      r_row_valid <= '0;
      for (int b = 0; b < NumBanks; b++) begin
        r_state[b]    <= S_IDLE;
        r_cnt[b]      <= '0;
        r_id[b]       <= '0;
        r_row[b]      <= '0;
        r_open_row[b] <= '0;
        r_delay[b]    <= '0;
      end
    end else begin
      r_lock <= w_rsp_valid && !rsp_ready_i;
      r_gnt  <= w_gnt;

      for (int b = 0; b < NumBanks; b++) begin
        // Delay runs from the handshake edge until the response is taken
        if (r_state[b] != S_IDLE) begin
          r_delay[b] <= sat_inc(r_delay[b]);
        end

        case (r_state[b])
          S_IDLE: begin
            if (w_req_hs && (w_req_bank == BankW'(b))) begin
              r_id[b]    <= req_id_i;
              r_row[b]   <= w_req_row;
              r_hit[b]   <= 1'b0;
              r_delay[b] <= '0;
              if (r_row_valid[b] && (r_open_row[b] == w_req_row)) begin
                r_state[b] <= S_ACC;
                r_cnt[b]   <= phase_load(RowHitCost);
                r_hit[b]   <= 1'b1;
              end else if (r_row_valid[b]) begin
                r_state[b] <= S_PRE;
                r_cnt[b]   <= phase_load(PrechargeCost);
              end else begin
                r_state[b] <= S_ACT;
                r_cnt[b]   <= phase_load(ActivationCost);
              end
            end
          end

          S_PRE: begin
            if (r_cnt[b] == '0) begin
              r_state[b]     <= S_ACT;
              r_cnt[b]       <= phase_load(ActivationCost);
              r_row_valid[b] <= 1'b0;
            end else begin
              r_cnt[b] <= r_cnt[b] - 1'b1;
            end
          end

          S_ACT: begin
            if (r_cnt[b] == '0) begin
              r_state[b]     <= S_ACC;
              r_cnt[b]       <= phase_load(RowHitCost);
              r_row_valid[b] <= 1'b1;
              r_open_row[b]  <= r_row[b];
            end else begin
              r_cnt[b] <= r_cnt[b] - 1'b1;
            end
          end

          S_ACC: begin
            if (r_cnt[b] == '0) begin
              r_state[b] <= S_DONE;
              if (!OpenPage) begin
                r_row_valid[b] <= 1'b0;
              end
            end else begin
              r_cnt[b] <= r_cnt[b] - 1'b1;
            end
          end

          S_DONE: begin
            if (w_rsp_hs && (w_gnt == BankW'(b))) begin
              r_state[b] <= S_IDLE;
            end
          end

          default: r_state[b] <= S_IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_simmem_bank_timing.sv
module tb_simmem_bank_timing;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n;
  logic        req_valid, req_ready;
  logic [15:0] req_addr;
  logic [1:0]  req_id;
  logic        rsp_valid, rsp_ready;
  logic [1:0]  rsp_id;
  logic [5:0]  rsp_delay;
  logic        rsp_hit;
  logic [3:0]  busy;

  // Closed-page instance, driven only by its own directed sequence
  logic        c_req_valid, c_req_ready;
  logic [15:0] c_req_addr;
  logic [1:0]  c_req_id;
  logic        c_rsp_valid, c_rsp_ready;
  logic [1:0]  c_rsp_id;
  logic [5:0]  c_rsp_delay;
  logic        c_rsp_hit;
  logic [3:0]  c_busy;

  simmem_bank_timing dut (
    .clk_i(clk), .rst_ni(rst_n),
    .req_valid_i(req_valid), .req_ready_o(req_ready),
    .req_addr_i(req_addr), .req_id_i(req_id),
    .rsp_valid_o(rsp_valid), .rsp_ready_i(rsp_ready),
    .rsp_id_o(rsp_id), .rsp_delay_o(rsp_delay), .rsp_row_hit_o(rsp_hit),
    .bank_busy_o(busy)
  );

  simmem_bank_timing #(.OpenPage(1'b0)) dut_cp (
    .clk_i(clk), .rst_ni(rst_n),
    .req_valid_i(c_req_valid), .req_ready_o(c_req_ready),
    .req_addr_i(c_req_addr), .req_id_i(c_req_id),
    .rsp_valid_o(c_rsp_valid), .rsp_ready_i(c_rsp_ready),
    .rsp_id_o(c_rsp_id), .rsp_delay_o(c_rsp_delay), .rsp_row_hit_o(c_rsp_hit),
    .bank_busy_o(c_busy)
  );

  int n_cmp  = 0;
  int n_fail = 0;

  function automatic void check(input string name, input longint act, input longint exp);
    n_cmp++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endfunction

  // ---------------------------------------------------------------------------
  // Transaction-level model (open page, default costs): each busy bank carries
  // the edge index of its handshake and its latency; it is complete once the
  // cycle count has advanced by that latency.
  // ---------------------------------------------------------------------------
  int   cyc = 0;
  bit   m_busy [4];
  int   m_start[4];
  int   m_lat  [4];
  int   m_id   [4];
  bit   m_hit  [4];
  bit   m_rv   [4];
  int   m_row  [4];
  bit   m_lock = 1'b0;
  int   m_gnt  = 0;

  function automatic int m_sel();
    if (m_lock) return m_gnt;
    for (int b = 0; b < 4; b++)
      if (m_busy[b] && (cyc >= m_start[b] + m_lat[b])) return b;
    return -1;
  endfunction

  // Compare on the falling edge, then advance the model by the upcoming
  // rising edge using the inputs, which are stable until then.
  initial begin
    for (int b = 0; b < 4; b++) begin
      m_busy[b] = 0; m_rv[b] = 0; m_start[b] = 0; m_lat[b] = 0;
      m_id[b] = 0; m_hit[b] = 0; m_row[b] = 0;
    end
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        check("rst_rsp_valid", rsp_valid, 0);
        check("rst_rsp_id", rsp_id, 0);
        check("rst_rsp_delay", rsp_delay, 0);
        check("rst_rsp_hit", rsp_hit, 0);
        check("rst_busy", busy, 0);
        check("rst_req_ready", req_ready, 0);
        for (int b = 0; b < 4; b++) begin m_busy[b] = 0; m_rv[b] = 0; end
        m_lock = 0;
        cyc = cyc + 1;
      end else begin
        int g, rb, rr, d;
        logic [3:0] eb;
        bit hs;
        g  = m_sel();
        rb = int'(req_addr[9:8]);
        rr = int'(req_addr[15:10]);
        eb = '0;
        for (int b = 0; b < 4; b++) eb[b] = m_busy[b];
        d = (g >= 0) ? cyc - m_start[g] : 0;
        if (d > 63) d = 63;
        check("mdl_rsp_valid", rsp_valid, (g >= 0));
        check("mdl_rsp_id", rsp_id, (g >= 0) ? m_id[g] : 0);
        check("mdl_rsp_delay", rsp_delay, d);
        check("mdl_rsp_hit", rsp_hit, (g >= 0) ? m_hit[g] : 0);
        check("mdl_busy", busy, eb);
        check("mdl_req_ready", req_ready, !m_busy[rb]);

        hs = req_valid && !m_busy[rb];
        if (g >= 0) begin
          if (rsp_ready) begin
            m_busy[g] = 0;
            m_lock    = 0;
          end else begin
            m_lock = 1;
            m_gnt  = g;
          end
        end
        cyc = cyc + 1;
        if (hs) begin
          m_busy[rb]  = 1;
          m_start[rb] = cyc;
          m_id[rb]    = int'(req_id);
          m_hit[rb]   = m_rv[rb] && (m_row[rb] == rr);
          m_lat[rb]   = m_hit[rb] ? 4 : (m_rv[rb] ? 7 : 5);
          m_rv[rb]    = 1;
          m_row[rb]   = rr;
        end
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Stimulus helpers; all are entered and left 1 time unit after a rising edge
  // ---------------------------------------------------------------------------
  task automatic do_req(input logic [15:0] a, input logic [1:0] id);
    bit ok;
    ok = 0;
    req_addr  = a;
    req_id    = id;
    req_valid = 1'b1;
    for (int n = 0; n < 40 && !ok; n++) begin
      @(negedge clk);
      if (req_ready) ok = 1;
      @(posedge clk); #1;
    end
    req_valid = 1'b0;
    if (!ok) check("req_timeout", 0, 1);
  endtask

  task automatic wait_rsp(output int lat);
    lat = 0;
    for (int n = 0; n < 100; n++) begin
      @(posedge clk); #1;
      lat++;
      if (rsp_valid) break;
    end
    if (!rsp_valid) check("rsp_timeout", 0, 1);
  endtask

  task automatic expect_rsp(input string tag, input int lat_e, input int id_e,
                            input int dly_e, input int hit_e);
    int lat;
    wait_rsp(lat);
    check({tag, "_lat"}, lat, lat_e);
    check({tag, "_id"}, rsp_id, id_e);
    check({tag, "_delay"}, rsp_delay, dly_e);
    check({tag, "_hit"}, rsp_hit, hit_e);
  endtask

  initial begin
    int lat;
    bit ok;
    rst_n       = 1'b0;
    req_valid   = 1'b0; req_addr   = '0; req_id   = '0; rsp_ready   = 1'b1;
    c_req_valid = 1'b0; c_req_addr = '0; c_req_id = '0; c_rsp_ready = 1'b1;

    repeat (2) @(posedge clk);
    #1;
    check("reset_ready", req_ready, 0);
    check("reset_valid", rsp_valid, 0);
    check("reset_busy", busy, 0);
    rst_n = 1'b1;
    #1;
    check("idle_ready", req_ready, 1);
    @(posedge clk); #1;

    // Closed page: the row is closed after every access, so a repeat is 5 cycles
    c_req_addr = 16'h0100;
    c_req_id   = 2'd1;
    for (int k = 0; k < 2; k++) begin
      ok = 0;
      c_req_valid = 1'b1;
      for (int n = 0; n < 40 && !ok; n++) begin
        @(negedge clk);
        if (c_req_ready) ok = 1;
        @(posedge clk); #1;
      end
      c_req_valid = 1'b0;
      if (!ok) check("cp_req_timeout", 0, 1);
      lat = 0;
      for (int n = 0; n < 100; n++) begin
        @(posedge clk); #1;
        lat++;
        if (c_rsp_valid) break;
      end
      check("cp_lat", lat, 5);
      check("cp_delay", c_rsp_delay, 5);
      check("cp_hit", c_rsp_hit, 0);
      check("cp_id", c_rsp_id, 1);
      @(posedge clk); #1;
    end

    // Closed row, then hit, then conflict on bank 1
    do_req(16'h0100, 2'd1);
    expect_rsp("closed", 5, 1, 5, 0);
    do_req(16'h0180, 2'd2);
    expect_rsp("hit", 4, 2, 4, 1);
    do_req(16'h0500, 2'd3);
    expect_rsp("conflict", 7, 3, 7, 0);
    @(posedge clk); #1;

    // Two banks in flight under backpressure; grant held on bank 2
    rsp_ready = 1'b0;
    do_req(16'h0200, 2'd0);
    do_req(16'h0000, 2'd1);
    req_addr  = 16'h0204;
    req_id    = 2'd3;
    req_valid = 1'b1;
    @(negedge clk);
    check("busy_bank_ready", req_ready, 0);
    @(posedge clk); #1;
    req_valid = 1'b0;
    wait_rsp(lat);
    for (int i = 0; i < 3; i++) begin
      check("hold_valid", rsp_valid, 1);
      check("hold_id", rsp_id, 0);
      @(posedge clk); #1;
    end
    check("held_id", rsp_id, 0);
    check("held_delay", rsp_delay, 8);
    rsp_ready = 1'b1;
    @(posedge clk); #1;
    check("second_valid", rsp_valid, 1);
    check("second_id", rsp_id, 1);
    check("second_delay", rsp_delay, 8);
    @(posedge clk); #1;
    check("drained_valid", rsp_valid, 0);

    // Delay saturation on a bank 0 hit
    rsp_ready = 1'b0;
    do_req(16'h0010, 2'd2);
    wait_rsp(lat);
    check("sat_hit", rsp_hit, 1);
    for (int i = 0; i < 70; i++) begin
      check("sat_busy0", busy[0], 1);
      @(posedge clk); #1;
    end
    check("sat_delay", rsp_delay, 63);
    rsp_ready = 1'b1;
    @(posedge clk); #1;
    check("sat_drained", rsp_valid, 0);

    // Reset in the middle of a bank 3 precharge
    do_req(16'h0300, 2'd0);
    expect_rsp("b3_open", 5, 0, 5, 0);
    @(posedge clk); #1;
    do_req(16'h0700, 2'd1);
    check("pre_busy3", busy[3], 1);
    rst_n = 1'b0;
    #1;
    check("midrst_valid", rsp_valid, 0);
    check("midrst_busy", busy, 0);
    check("midrst_delay", rsp_delay, 0);
    check("midrst_ready", req_ready, 0);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    do_req(16'h0700, 2'd2);
    expect_rsp("after_rst", 5, 2, 5, 0);
    @(posedge clk); #1;
    @(posedge clk); #1;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
